// File: rtl/keypad_scan_pkg.sv
// Shared constants, FSM state encoding and row-decode helper for the 4x4 keypad scanner.
package keypad_scan_pkg;

  localparam int BCD_BIT_WIDTH  = 4;
  localparam int KEY_CODE_WIDTH = BCD_BIT_WIDTH;
  localparam int KEYPAD_ROWS    = 4;
  localparam int KEYPAD_COLS    = 4;

  typedef enum logic [1:0] {
    KS_SCAN     = 2'd0,
    KS_PRESS_DB = 2'd1,
    KS_HELD     = 2'd2,
    KS_REL_DB   = 2'd3
  } ks_state_e;

  // Index of the highest low row; only meaningful when exactly one row is low.
  function automatic logic [1:0] row_index(input logic [KEYPAD_ROWS-1:0] low);
    row_index = 2'd0;
    for (int i = 0; i < KEYPAD_ROWS; i++) begin
      if (low[i]) row_index = i[1:0];
    end
  endfunction

endpackage

// File: rtl/keypad_scan_map.sv
// Combinational keypad legend: (column index, row index) -> hex key code.
module keypad_map
  import keypad_scan_pkg::*;
(
  input  logic [1:0]                col_idx,
  input  logic [1:0]                row_idx,
  output logic [KEY_CODE_WIDTH-1:0] code
);

  always_comb begin
    code = '0;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = '0;
    endcase
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one-cold column drive, synchronized active-low rows, press/release debounce.
// Output protocol: key_valid is a single-cycle pulse with key_code valid alongside; there is no back-pressure.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [KEYPAD_ROWS-1:0]    row_n,
  output logic [KEYPAD_COLS-1:0]    col_n,
  output logic [KEY_CODE_WIDTH-1:0] key_code,
  output logic                      key_valid,
  output logic                      key_down,
  output ks_state_e                 dbg_state
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [CW-1:0] DB_TH     = CW'(DEBOUNCE_SCANS);

  logic [KEYPAD_ROWS-1:0]    row_meta_q, row_sync_q;
  logic [SW-1:0]             slot_q, slot_d;
  logic [1:0]                col_q, col_d;
  logic [1:0]                row_idx_q, row_idx_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [KEY_CODE_WIDTH-1:0] key_code_q, key_code_d;
  logic                      key_valid_q, key_valid_d;
  logic                      key_down_q, key_down_d;
  ks_state_e                 state_q, state_d;

  logic                      sample, single, none, accept, release_ok;
  logic [KEYPAD_ROWS-1:0]    row_low;
  logic [1:0]                cur_row;
  logic [KEY_CODE_WIDTH-1:0] map_code;

  assign row_low = ~row_sync_q;
  assign single  = $onehot(row_low);
  assign none    = (row_low == '0);
  assign cur_row = row_index(row_low);
  assign sample  = (slot_q == SLOT_LAST);
  assign slot_d  = sample ? '0 : slot_q + 1'b1;

  keypad_map u_map (
    .col_idx (col_q),
    .row_idx (cur_row),
    .code    (map_code)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    accept      = 1'b0;
    release_ok  = 1'b0;
    if (sample) begin
      case (state_q)
        KS_SCAN: begin
          if (single) begin
            row_idx_d = cur_row;
            if (DEBOUNCE_SCANS == 1) begin
              accept = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = KS_PRESS_DB;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        KS_PRESS_DB: begin
          if (single && cur_row == row_idx_q) begin
            if (cnt_q == DB_LAST) accept = 1'b1;
            else                  cnt_d  = cnt_q + 1'b1;
          end else begin
            state_d = KS_SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = '0;
          end
        end
        // Column stays frozen while held, so a second key can never be accepted here.
        KS_HELD: begin
          if (none) begin
            if (DEBOUNCE_SCANS == 1) begin
              release_ok = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = KS_REL_DB;
            end
          end
        end
        KS_REL_DB: begin
          if (none) begin
            if (cnt_q == DB_LAST) release_ok = 1'b1;
            else                  cnt_d      = cnt_q + 1'b1;
          end else begin
            state_d = KS_HELD;
            cnt_d   = DB_TH;
          end
        end
        default: state_d = KS_SCAN;
      endcase
    end
    if (accept) begin
      key_code_d  = map_code;
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      cnt_d       = DB_TH;
      state_d     = KS_HELD;
    end
    if (release_ok) begin
      key_down_d = 1'b0;
      cnt_d      = '0;
      col_d      = col_q + 2'd1;
      state_d    = KS_SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q  <= '1;
      row_sync_q  <= '1;
      slot_q      <= '0;
      col_q       <= '0;
      row_idx_q   <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      state_q     <= KS_SCAN;
    end else begin
      row_meta_q  <= row_n;
      row_sync_q  <= row_meta_q;
      slot_q      <= slot_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      state_q     <= state_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign dbg_state = state_q;

endmodule
